// File: rtl/calc_pkg.sv
// Shared definitions for the four-port calculator: widths, command/response
// codes, engine state type and the unsigned ALU used by every port engine.
package calc_pkg;

  localparam int DW    = 32;
  localparam int NPORT = 4;
  localparam int CW    = 4;
  localparam int RW    = 2;
  localparam int SHW   = $clog2(DW);

  localparam logic [CW-1:0] CMD_NOP = 4'd0;
  localparam logic [CW-1:0] CMD_ADD = 4'd1;
  localparam logic [CW-1:0] CMD_SUB = 4'd2;
  localparam logic [CW-1:0] CMD_SHL = 4'd5;
  localparam logic [CW-1:0] CMD_SHR = 4'd6;

  localparam logic [RW-1:0] RSP_NONE = 2'd0;
  localparam logic [RW-1:0] RSP_OK   = 2'd1;
  localparam logic [RW-1:0] RSP_ERR  = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    OPND2 = 1'b1
  } state_t;

  typedef struct packed {
    logic [RW-1:0] resp;
    logic [DW-1:0] data;
  } calc_rsp_t;

  // Any failing or unknown operation reports RSP_ERR with a zero result.
  function automatic calc_rsp_t calc_alu(input logic [CW-1:0] cmd,
                                         input logic [DW-1:0] op1,
                                         input logic [DW-1:0] op2);
    calc_rsp_t   r;
    logic [DW:0] sum;
    r.resp = RSP_ERR;
    r.data = '0;
    sum    = {1'b0, op1} + {1'b0, op2};
    case (cmd)
      CMD_ADD: begin
        if (!sum[DW]) begin
          r.resp = RSP_OK;
          r.data = sum[DW-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          r.resp = RSP_OK;
          r.data = op1 - op2;
        end
      end
      CMD_SHL: begin
        r.resp = RSP_OK;
        r.data = op1 << op2[SHW-1:0];
      end
      CMD_SHR: begin
        r.resp = RSP_OK;
        r.data = op1 >> op2[SHW-1:0];
      end
      default: begin
        r.resp = RSP_ERR;
        r.data = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_if.sv
// One requester port of the calculator: command/operand in, response/result out.
interface calc_if;
  import calc_pkg::*;

  logic [CW-1:0] cmd;
  logic [DW-1:0] data;
  logic [RW-1:0] resp;
  logic [DW-1:0] result;

  modport master (output cmd, output data, input resp, input result);
  modport slave  (input cmd, input data, output resp, output result);
endinterface

// File: rtl/calc_port_engine.sv
// Per-port engine: two-state operand collector, ALU and registered one-cycle
// response. Outputs come only from flops, so they never depend on live inputs.
module calc_port_engine
  import calc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  calc_if.slave  port
);

  state_t        state_q, state_d;
  logic [CW-1:0] cmd_q,   cmd_d;
  logic [DW-1:0] op1_q,   op1_d;
  logic [RW-1:0] resp_q,  resp_d;
  logic [DW-1:0] data_q,  data_d;
  calc_rsp_t     alu_res;

  assign alu_res = calc_alu(cmd_q, op1_q, port.data);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    resp_d  = RSP_NONE;
    data_d  = '0;
    case (state_q)
      IDLE: begin
        if (port.cmd != CMD_NOP) begin
          cmd_d   = port.cmd;
          op1_d   = port.data;
          state_d = OPND2;
        end
      end
      OPND2: begin
        // Command lane is ignored here; the captured command owns this cycle.
        resp_d  = alu_res.resp;
        data_d  = alu_res.data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments in sequential logic so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      resp_q  <= RSP_NONE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
    end
  end

  assign port.resp   = resp_q;
  assign port.result = data_q;

endmodule

// File: rtl/calc_1.sv
// Four-port 32-bit calculator: four independent engines, one per requester.
// Big-endian [0:N-1] port vectors map MSB-to-MSB onto the internal [N-1:0] form.
module calc_1
  import calc_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset,
  input  logic [0:CW-1] req1_cmd_in,
  input  logic [0:DW-1] req1_data_in,
  input  logic [0:CW-1] req2_cmd_in,
  input  logic [0:DW-1] req2_data_in,
  input  logic [0:CW-1] req3_cmd_in,
  input  logic [0:DW-1] req3_data_in,
  input  logic [0:CW-1] req4_cmd_in,
  input  logic [0:DW-1] req4_data_in,
  output logic [0:RW-1] out_resp1,
  output logic [0:RW-1] out_resp2,
  output logic [0:RW-1] out_resp3,
  output logic [0:RW-1] out_resp4,
  output logic [0:DW-1] out_data1,
  output logic [0:DW-1] out_data2,
  output logic [0:DW-1] out_data3,
  output logic [0:DW-1] out_data4
);

  calc_if port_if [NPORT] ();

  assign port_if[0].cmd  = req1_cmd_in;
  assign port_if[0].data = req1_data_in;
  assign port_if[1].cmd  = req2_cmd_in;
  assign port_if[1].data = req2_data_in;
  assign port_if[2].cmd  = req3_cmd_in;
  assign port_if[2].data = req3_data_in;
  assign port_if[3].cmd  = req4_cmd_in;
  assign port_if[3].data = req4_data_in;

  assign out_resp1 = port_if[0].resp;
  assign out_data1 = port_if[0].result;
  assign out_resp2 = port_if[1].resp;
  assign out_data2 = port_if[1].result;
  assign out_resp3 = port_if[2].resp;
  assign out_data3 = port_if[2].result;
  assign out_resp4 = port_if[3].resp;
  assign out_data4 = port_if[3].result;

  for (genvar g = 0; g < NPORT; g++) begin : g_eng
    calc_port_engine u_eng (
      .clk   (c_clk),
      .rst_n (reset),
      .port  (port_if[g])
    );
  end

endmodule

// File: tb/tb_calc_1.sv
// Directed bench for calc_1: hand-computed vectors on single, parallel and
// back-to-back traffic, plus reset behaviour.
module tb_calc_1;
  import calc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  calc_if p1 (), p2 (), p3 (), p4 ();

  calc_1 dut (
    .c_clk        (clk),
    .reset        (rst_n),
    .req1_cmd_in  (p1.cmd),
    .req1_data_in (p1.data),
    .req2_cmd_in  (p2.cmd),
    .req2_data_in (p2.data),
    .req3_cmd_in  (p3.cmd),
    .req3_data_in (p3.data),
    .req4_cmd_in  (p4.cmd),
    .req4_data_in (p4.data),
    .out_resp1    (p1.resp),
    .out_resp2    (p2.resp),
    .out_resp3    (p3.resp),
    .out_resp4    (p4.resp),
    .out_data1    (p1.result),
    .out_data2    (p2.result),
    .out_data3    (p3.result),
    .out_data4    (p4.result)
  );

  typedef struct {
    string         tag;
    logic [CW-1:0] cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] resp;
    logic [DW-1:0] data;
  } vec_t;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [CW-1:0] c, input logic [DW-1:0] d);
    case (p)
      1: begin p1.cmd = c; p1.data = d; end
      2: begin p2.cmd = c; p2.data = d; end
      3: begin p3.cmd = c; p3.data = d; end
      default: begin p4.cmd = c; p4.data = d; end
    endcase
  endtask

  function automatic logic [RW-1:0] get_resp(input int p);
    case (p)
      1: return p1.resp;
      2: return p2.resp;
      3: return p3.resp;
      default: return p4.resp;
    endcase
  endfunction

  function automatic logic [DW-1:0] get_data(input int p);
    case (p)
      1: return p1.result;
      2: return p2.result;
      3: return p3.result;
      default: return p4.result;
    endcase
  endfunction

  task automatic expect_rsp(input int p, input string tag, input logic [RW-1:0] r,
                            input logic [DW-1:0] d);
    check($sformatf("p%0d_%s_resp", p, tag), DW'(get_resp(p)), DW'(r));
    check($sformatf("p%0d_%s_data", p, tag), get_data(p), d);
  endtask

  // Cmd+op1 in cycle N, op2 in N+1, response checked in N+2 and gone in N+3.
  task automatic run_op(input int p, input vec_t v);
    @(negedge clk) set_req(p, v.cmd, v.a);
    @(negedge clk) expect_rsp(p, {v.tag, "_early"}, RSP_NONE, '0);
    set_req(p, CMD_NOP, v.b);
    @(negedge clk) expect_rsp(p, v.tag, v.resp, v.data);
    set_req(p, CMD_NOP, '0);
    @(negedge clk) expect_rsp(p, {v.tag, "_clr"}, RSP_NONE, '0);
  endtask

  vec_t vecs [15];
  vec_t par  [4];

  initial begin
    vecs[0]  = '{"add_a",   CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF, RSP_OK,  32'h2000_0000};
    vecs[1]  = '{"add_b",   CMD_ADD, 32'h1FFF_FFFF, 32'h1FFF_FFFF, RSP_OK,  32'h3FFF_FFFE};
    vecs[2]  = '{"add_0",   CMD_ADD, 32'h0,         32'h0,         RSP_OK,  32'h0};
    vecs[3]  = '{"add_ovf", CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, RSP_ERR, 32'h0};
    vecs[4]  = '{"add_max", CMD_ADD, 32'h8000_0000, 32'h7FFF_FFFF, RSP_OK,  32'hFFFF_FFFF};
    vecs[5]  = '{"sub_udf", CMD_SUB, 32'd5,         32'd7,         RSP_ERR, 32'h0};
    vecs[6]  = '{"sub_ok",  CMD_SUB, 32'd7,         32'd5,         RSP_OK,  32'd2};
    vecs[7]  = '{"sub_eq",  CMD_SUB, 32'd9,         32'd9,         RSP_OK,  32'h0};
    vecs[8]  = '{"shl_31",  CMD_SHL, 32'h0000_0001, 32'd31,        RSP_OK,  32'h8000_0000};
    vecs[9]  = '{"shr_24",  CMD_SHR, 32'h8000_0000, 32'h0000_0024, RSP_OK,  32'h0800_0000};
    vecs[10] = '{"shl_0",   CMD_SHL, 32'h0000_1234, 32'd0,         RSP_OK,  32'h0000_1234};
    vecs[11] = '{"shl_32",  CMD_SHL, 32'hFFFF_FFFF, 32'h0000_0020, RSP_OK,  32'hFFFF_FFFF};
    vecs[12] = '{"cmd3",    4'd3,    32'd10,        32'd20,        RSP_ERR, 32'h0};
    vecs[13] = '{"cmd4",    4'd4,    32'd10,        32'd20,        RSP_ERR, 32'h0};
    vecs[14] = '{"cmd15",   4'd15,   32'd10,        32'd20,        RSP_ERR, 32'h0};

    par[0] = '{"par", CMD_ADD, 32'd10,        32'd20, RSP_OK,  32'd30};
    par[1] = '{"par", CMD_SUB, 32'd3,         32'd9,  RSP_ERR, 32'h0};
    par[2] = '{"par", CMD_SHL, 32'h0000_000F, 32'd4,  RSP_OK,  32'h0000_00F0};
    par[3] = '{"par", CMD_SHR, 32'hFFFF_FFFF, 32'd31, RSP_OK,  32'h0000_0001};

    for (int p = 1; p <= NPORT; p++) set_req(p, CMD_NOP, '0);

    // Reset held for four cycles, then all outputs must be idle.
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int p = 1; p <= NPORT; p++) expect_rsp(p, "rst", RSP_NONE, '0);

    for (int i = 0; i < 15; i++) run_op(1, vecs[i]);

    // All ports issue different commands in the same cycle.
    @(negedge clk) for (int p = 1; p <= NPORT; p++) set_req(p, par[p-1].cmd, par[p-1].a);
    @(negedge clk) for (int p = 1; p <= NPORT; p++) set_req(p, CMD_NOP, par[p-1].b);
    @(negedge clk) for (int p = 1; p <= NPORT; p++) begin
      expect_rsp(p, "par", par[p-1].resp, par[p-1].data);
      set_req(p, CMD_NOP, '0);
    end

    // Port 2 back-to-back: new command issued alongside each response.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) expect_rsp(2, $sformatf("b2b%0d", i-1), RSP_OK, DW'(i + 100*(i-1)));
      set_req(2, CMD_ADD, DW'(i+1));
      @(negedge clk) expect_rsp(2, $sformatf("b2b%0d_gap", i), RSP_NONE, '0);
      set_req(2, CMD_NOP, DW'(100*i));
    end
    @(negedge clk) expect_rsp(2, "b2b3", RSP_OK, 32'd304);
    set_req(2, CMD_NOP, '0);

    // A command presented during the op2 cycle must be ignored.
    @(negedge clk) set_req(3, CMD_ADD, 32'd1);
    @(negedge clk) set_req(3, CMD_SUB, 32'd2);
    @(negedge clk) expect_rsp(3, "ign", RSP_OK, 32'd3);
    set_req(3, CMD_NOP, '0);
    @(negedge clk) expect_rsp(3, "ign_n3", RSP_NONE, '0);
    @(negedge clk) expect_rsp(3, "ign_n4", RSP_NONE, '0);

    // Reset asserted while the engine waits for op2 discards the operation.
    @(negedge clk) set_req(1, CMD_ADD, 32'd5);
    @(negedge clk) set_req(1, CMD_NOP, 32'd6);
    #2 rst_n = 1'b0;
    @(negedge clk) expect_rsp(1, "rst_in", RSP_NONE, '0);
    set_req(1, CMD_NOP, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) expect_rsp(1, $sformatf("rst_post%0d", i), RSP_NONE, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
